// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM plus a small IO block with TX/RX FIFOs,
// a status register and a sticky halt flag. Reads return one cycle later.
module mem_responder #(
   parameter int RAM_AW   = 17,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        w_r,
   input  logic [31:0] addr_input,
   input  logic [7:0]  data_input,
   output logic [7:0]  data_output,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        program_finished,
   output logic        tx_overflow
);

   localparam int TXW = $clog2(TX_DEPTH);
   localparam int RXW = $clog2(RX_DEPTH);
   localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
   localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

   logic [7:0] ram [2**RAM_AW];
   logic [RAM_AW-1:0] idx;
   logic [2:0] off;
   logic is_io;
   logic unused_addr;

   assign idx         = addr_input[RAM_AW-1:0];
   assign off         = addr_input[2:0];
   assign is_io       = addr_input[17:16] == 2'b11;
   assign unused_addr = ^addr_input[31:18];

   logic io_rd_cyc;
   logic io_wr_cyc;
   assign io_rd_cyc = rdy && !w_r && is_io;
   assign io_wr_cyc = rdy && w_r && is_io;

   logic [7:0] tx_mem [TX_DEPTH];
   logic [TXW-1:0] tx_wr;
   logic [TXW-1:0] tx_rd;
   logic [TXW:0] tx_cnt;
   logic tx_full;
   logic tx_req;
   logic tx_push;
   logic tx_pop;

   assign tx_full        = tx_cnt == TX_FULL;
   assign tx_valid       = tx_cnt != '0;
   assign tx_data        = tx_mem[tx_rd];
   assign io_buffer_full = tx_full;
   assign tx_pop         = tx_valid && tx_ready && rdy;
   assign tx_req         = io_wr_cyc && off == 3'd0;
   // A full FIFO still accepts when the host drains a slot this cycle.
   assign tx_push        = tx_req && (!tx_full || tx_pop);

   logic [7:0] rx_mem [RX_DEPTH];
   logic [RXW-1:0] rx_wr;
   logic [RXW-1:0] rx_rd;
   logic [RXW:0] rx_cnt;
   logic rx_nonempty;
   logic rx_push;
   logic rx_pop;

   assign rx_nonempty = rx_cnt != '0;
   assign rx_ready    = rx_cnt != RX_FULL;
   assign rx_push     = rx_valid && rx_ready && rdy;
   assign rx_pop      = io_rd_cyc && off == 3'd0 && rx_nonempty;

   logic [7:0] io_rd;

   always_comb begin
      io_rd = 8'h00;
      unique case (off)
         3'd0: io_rd = rx_nonempty ? rx_mem[rx_rd] : 8'h00;
         3'd4: io_rd = {6'b0, rx_nonempty, tx_full};
         default: io_rd = 8'h00;
      endcase
   end

   logic [7:0] ram_q;
   logic [7:0] io_q;
   logic sel_io;

   always_ff @(posedge clk) begin
      if (rdy && !is_io) begin
         if (w_r) ram[idx] <= data_input;
         else     ram_q    <= ram[idx];
      end
   end

   // Output mux select follows the decode of the cycle that issued the read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_io <= 1'b1;
         io_q   <= 8'h00;
      end else if (rdy && !w_r) begin
         sel_io <= is_io;
         if (is_io) io_q <= io_rd;
      end
   end

   assign data_output = sel_io ? io_q : ram_q;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= data_input;
      if (rx_push) rx_mem[rx_wr] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + TXW'(1);
         if (tx_pop)  tx_rd <= tx_rd + TXW'(1);
         unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + (TXW+1)'(1);
            2'b01:   tx_cnt <= tx_cnt - (TXW+1)'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wr  <= '0;
         rx_rd  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + RXW'(1);
         if (rx_pop)  rx_rd <= rx_rd + RXW'(1);
         unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + (RXW+1)'(1);
            2'b01:   rx_cnt <= rx_cnt - (RXW+1)'(1);
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         program_finished <= 1'b0;
         tx_overflow      <= 1'b0;
      end else begin
         if (io_wr_cyc && off == 3'd4) program_finished <= 1'b1;
         if (tx_req && !tx_push)       tx_overflow      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM path, IO FIFOs, status, halt, reset.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        w_r = 1'b0;
   logic [31:0] addr_input = '0;
   logic [7:0]  data_input = '0;
   logic [7:0]  data_output;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        program_finished;
   logic        tx_overflow;

   int vecs = 0;
   int errs = 0;

   localparam logic [31:0] IO = 32'h0003_0000;
   localparam logic [31:0] ST = 32'h0003_0004;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk(clk), .rst(rst), .rdy(rdy), .w_r(w_r),
      .addr_input(addr_input), .data_input(data_input),
      .data_output(data_output), .io_buffer_full(io_buffer_full),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .program_finished(program_finished), .tx_overflow(tx_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      vecs++;
      if (data_output !== 8'h00) begin
         errs++; $display("FAIL rst_dout got %h want 00", data_output);
      end
      vecs++;
      if (program_finished !== 1'b0 || tx_overflow !== 1'b0) begin
         errs++; $display("FAIL rst_flags got %b%b want 00", program_finished, tx_overflow);
      end
      vecs++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || io_buffer_full !== 1'b0) begin
         errs++; $display("FAIL rst_fifo got v%b r%b f%b want v0 r1 f0", tx_valid, rx_ready, io_buffer_full);
      end
      rst = 1'b1;
   endtask

   task automatic test_ram();
      w_r = 1'b1; addr_input = 32'h10; data_input = 8'hA5;
      step();
      vecs++;
      if (data_output !== 8'h00) begin
         errs++; $display("FAIL ram_wr_hold got %h want 00", data_output);
      end
      w_r = 1'b0;
      step();
      vecs++;
      if (data_output !== 8'hA5) begin
         errs++; $display("FAIL ram_rd got %h want a5", data_output);
      end
      addr_input = 32'h0004_0010;
      step();
      vecs++;
      if (data_output !== 8'hA5) begin
         errs++; $display("FAIL ram_alias got %h want a5", data_output);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [4];
      pat = '{8'h11, 8'h22, 8'h33, 8'h44};
      w_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr_input = 32'h100 + i; data_input = pat[i];
         step();
      end
      w_r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr_input = 32'h100 + i;
         step();
         vecs++;
         if (data_output !== pat[i]) begin
            errs++; $display("FAIL stream[%0d] got %h want %h", i, data_output, pat[i]);
         end
      end
   endtask

   task automatic test_tx_overflow();
      tx_ready = 1'b0; w_r = 1'b1; addr_input = IO;
      for (int i = 0; i < 9; i++) begin
         data_input = 8'hB0 + 8'(i);
         step();
         if (i == 7) begin
            vecs++;
            if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0) begin
               errs++; $display("FAIL tx_full8 got f%b o%b want f1 o0", io_buffer_full, tx_overflow);
            end
         end
      end
      vecs++;
      if (tx_overflow !== 1'b1) begin
         errs++; $display("FAIL tx_ovf got %b want 1", tx_overflow);
      end
      w_r = 1'b0; addr_input = 32'h0; tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vecs++;
         if (tx_valid !== 1'b1 || tx_data !== 8'hB0 + 8'(i)) begin
            errs++; $display("FAIL tx_drain[%0d] got v%b %h want v1 %h", i, tx_valid, tx_data, 8'hB0 + 8'(i));
         end
         step();
      end
      tx_ready = 1'b0;
      vecs++;
      if (tx_valid !== 1'b0) begin
         errs++; $display("FAIL tx_empty got %b want 0", tx_valid);
      end
   endtask

   task automatic test_full_push_pop();
      pulse_reset();
      tx_ready = 1'b0; w_r = 1'b1; addr_input = IO;
      for (int i = 0; i < 8; i++) begin
         data_input = 8'hC0 + 8'(i);
         step();
      end
      data_input = 8'hC8; tx_ready = 1'b1;
      step();
      tx_ready = 1'b0; w_r = 1'b0; addr_input = 32'h0;
      vecs++;
      if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1 || tx_data !== 8'hC1) begin
         errs++; $display("FAIL pushpop got o%b f%b %h want o0 f1 c1", tx_overflow, io_buffer_full, tx_data);
      end
      tx_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         vecs++;
         if (tx_valid !== 1'b1 || tx_data !== 8'hC0 + 8'(i)) begin
            errs++; $display("FAIL pp_drain[%0d] got v%b %h want v1 %h", i, tx_valid, tx_data, 8'hC0 + 8'(i));
         end
         step();
      end
      tx_ready = 1'b0;
      vecs++;
      if (tx_valid !== 1'b0) begin
         errs++; $display("FAIL pp_empty got %b want 0", tx_valid);
      end
   endtask

   task automatic test_rx();
      w_r = 1'b0; addr_input = 32'h0;
      rx_valid = 1'b1; rx_data = 8'h7E;
      step();
      rx_valid = 1'b0;
      addr_input = ST;
      step();
      vecs++;
      if (data_output !== 8'h02) begin
         errs++; $display("FAIL rx_status got %h want 02", data_output);
      end
      addr_input = IO;
      step();
      vecs++;
      if (data_output !== 8'h7E) begin
         errs++; $display("FAIL rx_pop got %h want 7e", data_output);
      end
      step();
      vecs++;
      if (data_output !== 8'h00) begin
         errs++; $display("FAIL rx_pop_empty got %h want 00", data_output);
      end
      addr_input = ST;
      step();
      vecs++;
      if (data_output !== 8'h00) begin
         errs++; $display("FAIL rx_status_empty got %h want 00", data_output);
      end
      addr_input = 32'h0; rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'hD0 + 8'(i);
         step();
      end
      rx_valid = 1'b0;
      vecs++;
      if (rx_ready !== 1'b0) begin
         errs++; $display("FAIL rx_full got %b want 0", rx_ready);
      end
      addr_input = IO;
      for (int i = 0; i < 8; i++) begin
         step();
         vecs++;
         if (data_output !== 8'hD0 + 8'(i)) begin
            errs++; $display("FAIL rx_drain[%0d] got %h want %h", i, data_output, 8'hD0 + 8'(i));
         end
      end
      vecs++;
      if (rx_ready !== 1'b1) begin
         errs++; $display("FAIL rx_ready got %b want 1", rx_ready);
      end
   endtask

   task automatic test_rdy_and_misc();
      rdy = 1'b0; w_r = 1'b1; addr_input = ST;
      step();
      w_r = 1'b0; addr_input = 32'h10;
      step();
      vecs++;
      if (program_finished !== 1'b0 || data_output !== 8'hD7) begin
         errs++; $display("FAIL rdy_freeze got p%b %h want p0 d7", program_finished, data_output);
      end
      rdy = 1'b1; w_r = 1'b1; addr_input = IO + 1; data_input = 8'hFF;
      step();
      w_r = 1'b0;
      step();
      vecs++;
      if (data_output !== 8'h00 || tx_valid !== 1'b0) begin
         errs++; $display("FAIL io_other got %h v%b want 00 v0", data_output, tx_valid);
      end
   endtask

   task automatic test_halt_reset();
      tx_ready = 1'b0; w_r = 1'b1; addr_input = IO; data_input = 8'h55;
      step();
      addr_input = ST;
      step();
      vecs++;
      if (program_finished !== 1'b1) begin
         errs++; $display("FAIL halt got %b want 1", program_finished);
      end
      w_r = 1'b0; addr_input = 32'h10;
      step();
      vecs++;
      if (data_output !== 8'hA5 || tx_valid !== 1'b1) begin
         errs++; $display("FAIL pre_rst got %h v%b want a5 v1", data_output, tx_valid);
      end
      #2 rst = 1'b0;
      #1;
      vecs++;
      if (program_finished !== 1'b0 || tx_valid !== 1'b0 || data_output !== 8'h00) begin
         errs++; $display("FAIL async_rst got p%b v%b %h want p0 v0 00", program_finished, tx_valid, data_output);
      end
      #1 rst = 1'b1;
      step();
      vecs++;
      if (data_output !== 8'hA5) begin
         errs++; $display("FAIL ram_keep got %h want a5", data_output);
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_back_to_back();
      test_tx_overflow();
      test_full_push_pop();
      test_rx();
      test_rdy_and_misc();
      test_halt_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory port.
- Consumes the controller's w_r / addr_input / data_input each cycle and returns data_output with a fixed one-cycle read latency.
- Decodes addresses into a byte-addressed RAM region and a small memory-mapped IO region. The IO region holds a TX byte FIFO toward the host UART link, an RX byte FIFO from that link, a status register and a sticky halt flag.

Parameters:
- RAM_AW, 17, RAM address width; RAM holds 2^RAM_AW bytes.
- TX_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- RX_DEPTH, 8, RX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- w_r  in  1  1 = write cycle, 0 = read cycle.
- addr_input  in  32  byte address from memory controller.
- data_input  in  8  write byte.
- data_output  out  8  read byte, valid one cycle after the address was presented.
- io_buffer_full  out  1  TX FIFO full.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  host accepts head byte.
- rx_valid  in  1  host pushes rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  RX FIFO not full.
- program_finished  out  1  sticky halt flag.
- tx_overflow  out  1  sticky: a TX push was dropped.

Behaviour:
- Reset (rst=0, async):
  - data_output=0, program_finished=0, tx_overflow=0.
  - All FIFO pointers and counts 0, so tx_valid=0, rx_ready=1, io_buffer_full=0.
  - RAM contents are not reset.
- rdy=0: no register, FIFO or RAM update; outputs hold. The host-side rx_valid push is also ignored (host must hold rx_valid while rdy=0).
- Decode: IO when addr_input[17:16]==2'b11; otherwise RAM at addr_input[RAM_AW-1:0]. Bits 31:18 are ignored.
- RAM read (w_r=0):
  - data_output <= ram[idx] at the posedge, so the byte is visible the cycle after the address.
  - Back-to-back reads each return one cycle later; no bubbles.
- RAM write (w_r=1): ram[idx] <= data_input at the posedge. data_output holds its previous value.
- IO map, by addr_input[2:0] within the IO region:
  - offset 0, read: pops the RX head and returns it; if RX is empty, returns 0 with no pop.
  - offset 0, write: pushes data_input into TX.
    - If TX is full and no TX pop occurs that cycle, the byte is dropped and tx_overflow <= 1.
  - offset 4, read: returns {6'b0, rx_nonempty, tx_full}. No side effect.
  - offset 4, write: program_finished <= 1. Stays 1 until reset.
  - Any other offset: read returns 0, write is ignored.
- The IO read result is registered exactly like a RAM read: a one-cycle registered mux, selected by the decode of the previous cycle.
- TX FIFO:
  - tx_valid = count != 0; tx_data = mem[rd_ptr].
  - Pop on tx_valid && tx_ready && rdy.
  - Simultaneous push and pop: count unchanged, both pointers advance. When full, the push is accepted because the pop frees a slot in the same cycle.
  - Pointers wrap modulo TX_DEPTH.
  - io_buffer_full = (count == TX_DEPTH).
- RX FIFO:
  - Push on rx_valid && rx_ready && rdy; rx_ready = count != RX_DEPTH.
  - A push when full is impossible by handshake (host must wait).
  - Simultaneous host push and CPU pop: count unchanged.
  - A pop on empty is a no-op.
  - Pointers wrap modulo RX_DEPTH.
- A host push into an empty RX FIFO becomes readable by the CPU on the next cycle; no same-cycle bypass.
- Counts are $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits.

Test Plan:
- Write 0xA5 at 0x00000010 (w_r=1), then read 0x00000010 -> data_output=0xA5 exactly one cycle after the read address. A read of 0x00040010 (bit 18 set, bits 17:16=00) also returns 0xA5.
- Stream 4 reads of 0x100..0x103 after writing 0x11,0x22,0x33,0x44 -> data_output is 0x11,0x22,0x33,0x44 on consecutive cycles, each one cycle after its address.
- Hold tx_ready=0 and write 9 bytes to 0x30000 with TX_DEPTH=8:
  - io_buffer_full=1 after the 8th push and tx_overflow=1 after the 9th.
  - Release tx_ready=1 -> tx_data sequence equals the first 8 bytes, then tx_valid=0.
- With TX full, push to 0x30000 in the same cycle as tx_ready=1 -> the byte is accepted, tx_overflow stays 0, and the count stays 8.
- Host pushes 0x7E via rx_valid:
  - Next cycle, a read of 0x30004 returns 0x02.
  - A read of 0x30000 returns 0x7E.
  - A second read of 0x30000 returns 0x00 and status returns 0x00.
- Write to 0x30004 -> program_finished=1 the next cycle. Assert rst=0 mid-stream (async) -> program_finished, tx_valid and data_output go to 0 immediately; a previously written RAM byte is still readable after reset.
